// File: rtl/i2c_slave_regs.sv
// I2C target exposing an 8-bit register space: address byte, pointer byte, then data bytes.
// Define I2C_SLV_GLITCH_FILTER_EN to add a FILT_LEN-deep level filter on SCL/SDA.
module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         FILT_LEN = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       WR_EN,
  output logic [7:0] RD_ADDR,
  output logic       RD_REQ,
  input  logic [7:0] RD_DATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE
  } state_t;

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("FILT_LEN must be at least 1");
  end

  logic [1:0] scl_sync, sda_sync;
  logic       scl_lvl, sda_lvl;
  logic       scl_prev, sda_prev;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN + 1);
  logic [FCW-1:0] scl_cnt, sda_cnt;

  // A level is accepted only after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_lvl <= 1'b1;
      sda_lvl <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_sync[1] == scl_lvl) scl_cnt <= '0;
      else if (scl_cnt == FCW'(FILT_LEN - 1)) begin
        scl_lvl <= scl_sync[1];
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + 1'b1;
      if (sda_sync[1] == sda_lvl) sda_cnt <= '0;
      else if (sda_cnt == FCW'(FILT_LEN - 1)) begin
        sda_lvl <= sda_sync[1];
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + 1'b1;
    end
  end
`else
  assign scl_lvl = scl_sync[1];
  assign sda_lvl = sda_sync[1];
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_lvl;
      sda_prev <= sda_lvl;
    end
  end

  logic start_evt, stop_evt, scl_rise, scl_fall;
  assign start_evt = scl_lvl & scl_prev & sda_prev & ~sda_lvl;
  assign stop_evt  = scl_lvl & scl_prev & ~sda_prev & sda_lvl;
  assign scl_rise  = scl_lvl & ~scl_prev;
  assign scl_fall  = ~scl_lvl & scl_prev;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] byte_in;
  logic [7:0] ptr;
  logic [7:0] tx;
  logic       rw, ack_drv, ack_ok, rd_pend, sda_oe;
  logic       last_bit;

  assign byte_in  = {shreg, sda_lvl};
  assign last_bit = scl_rise && (bit_cnt == 4'd7);
  assign SDA      = sda_oe ? 1'b0 : 1'bz;

  // WR_EN and RD_REQ are single-cycle strobes with no back-pressure; the register
  // file must accept a write in that cycle and present RD_DATA exactly one CLK after RD_REQ.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      tx      <= '0;
      rw      <= 1'b0;
      ack_drv <= 1'b0;
      ack_ok  <= 1'b0;
      rd_pend <= 1'b0;
      sda_oe  <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= '0;
      WR_EN   <= 1'b0;
      RD_ADDR <= '0;
      RD_REQ  <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      WR_EN   <= 1'b0;
      RD_REQ  <= 1'b0;
      rd_pend <= RD_REQ;
      if (rd_pend) tx <= RD_DATA;

      if (stop_evt) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        BUSY   <= 1'b0;
      end else if (start_evt) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
        ack_ok  <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDAT: begin
            if (scl_rise) begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (last_bit) begin
              bit_cnt <= '0;
              ack_drv <= 1'b0;
              if (state == ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state <= ADDR_ACK;
                  rw    <= byte_in[0];
                  BUSY  <= 1'b1;
                  if (byte_in[0]) begin
                    RD_REQ  <= 1'b1;
                    RD_ADDR <= ptr;
                  end
                end else begin
                  state <= IGNORE;
                  BUSY  <= 1'b0;
                end
              end else if (state == PTR) begin
                ptr   <= byte_in;
                state <= PTR_ACK;
              end else begin
                WR_EN   <= 1'b1;
                WR_ADDR <= ptr;
                WR_DATA <= byte_in;
                ptr     <= ptr + 8'd1;
                state   <= WDAT_ACK;
              end
            end
          end
          // First SCL fall starts the ACK low, the next one (end of 9th clock) ends it.
          ADDR_ACK, PTR_ACK, WDAT_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                ack_drv <= 1'b1;
                sda_oe  <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                bit_cnt <= '0;
                if (state == ADDR_ACK && rw) begin
                  state  <= RDAT;
                  sda_oe <= ~tx[7];
                end else begin
                  state  <= (state == ADDR_ACK) ? PTR : WDAT;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          RDAT: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state  <= RDAT_ACK;
                sda_oe <= 1'b0;
                ack_ok <= 1'b0;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end
          RDAT_ACK: begin
            if (scl_rise) begin
              if (!sda_lvl) begin
                ack_ok  <= 1'b1;
                ptr     <= ptr + 8'd1;
                RD_ADDR <= ptr + 8'd1;
                RD_REQ  <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end else if (scl_fall && ack_ok) begin
              ack_ok  <= 1'b0;
              bit_cnt <= '0;
              state   <= RDAT;
              sda_oe  <= ~tx[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, register-file responder and a
// transaction-level reference model (pointer + register array) feeding expected queues.
module tb_i2c_slave_regs;

  localparam int         Q   = 100;
  localparam logic [6:0] DEV = 7'h42;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] rd_data = 8'h00;
  wire        sda;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic       wr_en, rd_req, busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_regs #(.DEV_ADDR(DEV), .FILT_LEN(3)) dut (
    .CLK(clk), .RESET(reset), .SCL(scl), .SDA(sda),
    .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_EN(wr_en),
    .RD_ADDR(rd_addr), .RD_REQ(rd_req), .RD_DATA(rd_data), .BUSY(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  dev_mem [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  model_ptr = 8'h00;
  logic [15:0] exp_wr_q[$];
  logic [15:0] got_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  got_rd_q[$];

  logic       pk_en = 1'b0;
  logic [7:0] pk_addr = 8'h00, pk_val = 8'h00;

  // Register file behind the target, plus the transaction monitor.
  always @(posedge clk) begin
    if (pk_en) dev_mem[pk_addr] <= pk_val;
    else if (wr_en) dev_mem[wr_addr] <= wr_data;
    if (rd_req) rd_data <= dev_mem[rd_addr];
    if (wr_en) got_wr_q.push_back({wr_addr, wr_data});
    if (rd_req) got_rd_q.push_back(rd_addr);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    pk_addr = a;
    pk_val  = v;
    pk_en   = 1'b1;
    @(posedge clk);
    #1;
    pk_en = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic bit_out(input logic b);
    m_low = ~b;
    #Q; scl = 1'b1;
    #(2*Q); scl = 1'b0;
    #Q;
  endtask

  task automatic bit_in(output logic b);
    m_low = 1'b0;
    #Q; scl = 1'b1;
    #Q; b = sda;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    #Q; scl = 1'b1;
    #Q; m_low = 1'b1;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    #Q; scl = 1'b1;
    #Q; m_low = 1'b0;
    #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      bit_in(x);
      b[i] = x;
    end
    bit_out(nack);
  endtask

  task automatic compare_queues();
    logic [15:0] gw, ew;
    logic [7:0]  gr, er;
    check_val("wr_count", got_wr_q.size(), exp_wr_q.size());
    while (got_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
      gw = got_wr_q.pop_front();
      ew = exp_wr_q.pop_front();
      check_val("wr_addr_data", {16'h0, gw}, {16'h0, ew});
    end
    check_val("rd_count", got_rd_q.size(), exp_rd_q.size());
    while (got_rd_q.size() > 0 && exp_rd_q.size() > 0) begin
      gr = got_rd_q.pop_front();
      er = exp_rd_q.pop_front();
      check_val("rd_addr", {24'h0, gr}, {24'h0, er});
    end
    got_wr_q.delete();
    exp_wr_q.delete();
    got_rd_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic do_write(input logic [7:0] ptr, input int n, input logic [31:0] data);
    logic       ack;
    logic [7:0] d, a;
    i2c_start();
    send_byte({DEV, 1'b0}, ack);
    check_val("wr_addr_ack", ack, 0);
    check_val("busy_on", busy, 1);
    send_byte(ptr, ack);
    check_val("wr_ptr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      d = data[8*i +: 8];
      a = ptr + 8'(i);
      send_byte(d, ack);
      check_val("wr_data_ack", ack, 0);
      exp_wr_q.push_back({a, d});
      ref_mem[a] = d;
    end
    model_ptr = ptr + 8'(n);
    i2c_stop();
    check_val("busy_off", busy, 0);
    compare_queues();
  endtask

  task automatic do_read(input int n, input logic set_ptr, input logic [7:0] ptr);
    logic       ack;
    logic [7:0] b, a;
    if (set_ptr) begin
      i2c_start();
      send_byte({DEV, 1'b0}, ack);
      check_val("rd_addrw_ack", ack, 0);
      send_byte(ptr, ack);
      check_val("rd_ptr_ack", ack, 0);
      model_ptr = ptr;
    end
    i2c_start();
    send_byte({DEV, 1'b1}, ack);
    check_val("rd_addrr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      a = model_ptr + 8'(i);
      exp_rd_q.push_back(a);
      recv_byte(b, i == n - 1);
      check_val("rd_byte", b, ref_mem[a]);
    end
    check_val("nack_release", sda, 1);
    model_ptr = model_ptr + 8'(n - 1);
    i2c_stop();
    check_val("busy_off", busy, 0);
    compare_queues();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] p;

    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
    check_val("rst_busy", busy, 0);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_rd_req", rd_req, 0);
    check_val("rst_wr_addr", wr_addr, 0);
    check_val("rst_wr_data", wr_data, 0);
    check_val("rst_rd_addr", rd_addr, 0);
    check_val("rst_sda", sda, 1);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    do_write(8'h10, 2, 32'h0000_5AA5);

    poke(8'h20, 8'h77);
    poke(8'h21, 8'h88);
    do_read(2, 1'b1, 8'h20);

    i2c_start();
    send_byte({7'h43, 1'b0}, ack);
    check_val("other_addr_ack", ack, 1);
    check_val("other_busy", busy, 0);
    send_byte(8'h55, ack);
    check_val("other_data_ack", ack, 1);
    i2c_stop();
    compare_queues();

    do_write(8'hFF, 2, 32'h0000_0201);

    i2c_start();
    send_byte({DEV, 1'b0}, ack);
    check_val("part_addr_ack", ack, 0);
    send_byte(8'h30, ack);
    check_val("part_ptr_ack", ack, 0);
    model_ptr = 8'h30;
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    i2c_stop();
    check_val("part_busy", busy, 0);
    do_write(8'h31, 1, $urandom());
    do_read(2, 1'b0, 8'h00);

`ifdef I2C_SLV_GLITCH_FILTER_EN
    i2c_start();
    send_byte({DEV, 1'b0}, ack);
    check_val("glitch_addr_ack", ack, 0);
    send_byte(8'h50, ack);
    check_val("glitch_ptr_ack", ack, 0);
    m_low = 1'b0;
    #Q; scl = 1'b1;
    #Q;
    @(negedge clk) m_low = 1'b1;
    @(negedge clk) m_low = 1'b0;
    #Q; scl = 1'b0;
    #Q;
    for (int i = 0; i < 7; i++) bit_out(1'b1);
    bit_in(ack);
    check_val("glitch_data_ack", ack, 0);
    check_val("glitch_busy", busy, 1);
    exp_wr_q.push_back({8'h50, 8'hFF});
    ref_mem[8'h50] = 8'hFF;
    model_ptr = 8'h51;
    i2c_stop();
    compare_queues();
`endif

    poke(model_ptr, 8'h3C);
    exp_rd_q.push_back(model_ptr);
    i2c_start();
    send_byte({DEV, 1'b1}, ack);
    check_val("rst_rd_ack", ack, 0);
    check_val("rdat_drive_low", sda, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("reset_sda_release", sda, 1);
    check_val("reset_busy", busy, 0);
    @(negedge clk) reset = 1'b0;
    i2c_stop();
    model_ptr = 8'h00;
    compare_queues();
    do_read(1, 1'b0, 8'h00);

    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        p = 8'($urandom_range(0, 255));
        do_write(p, int'($urandom_range(1, 3)), $urandom());
      end else begin
        p = 8'($urandom_range(0, 255));
        do_read(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), p);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
